// File: rtl/mem_bus_interface_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_interface_if
// Brief    : Control-side request bus plus the external memory bus used by
//            mem_bus_interface.
// Revision : 1.0
// ============================================================================
interface mem_bus_interface_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address_bus;
    logic                  rd_req;
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;

    // Bus-interface side
    modport slave (
        input  address_bus, rd_req, wr_req, wr_data, mem_rdata, mem_ready,
        output mem_addr, mem_rd, mem_wr, mem_wdata, rd_data, busy, done,
               timeout_err
    );

    // Control / memory side
    modport master (
        output address_bus, rd_req, wr_req, wr_data, mem_rdata, mem_ready,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, rd_data, busy, done,
               timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_interface.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_interface
// Brief    : Runs one read or write per request against external memory with
//            a ready handshake and a bounded wait; all outputs registered.
// Revision : 1.0
// ============================================================================
module mem_bus_interface #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_bus_interface_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2
    } state_t;

    // Wait-edge index on which a still-unready memory is abandoned
    localparam logic [7:0] c_last_wait = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q,       state_d;
    logic [7:0]            cnt_q,         cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q,     rd_data_d;
    logic                  mem_rd_q,      mem_rd_d;
    logic                  mem_wr_q,      mem_wr_d;
    logic                  busy_q,        busy_d;
    logic                  done_q,        done_d;
    logic                  timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rd_data_d     = rd_data_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.rd_req || bus.wr_req) begin
                    mem_addr_d    = bus.address_bus;
                    busy_d        = 1'b1;
                    cnt_d         = 8'd0;
                    timeout_err_d = 1'b0;
                    // Read wins when both requests are present
                    if (bus.rd_req) begin
                        mem_rd_d = 1'b1;
                        state_d  = READ_WAIT;
                    end else begin
                        mem_wdata_d = bus.wr_data;
                        mem_wr_d    = 1'b1;
                        state_d     = WRITE_WAIT;
                    end
                end
            end

            READ_WAIT, WRITE_WAIT: begin
                if (bus.mem_ready) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                    if (state_q == READ_WAIT) begin
                        rd_data_d = bus.mem_rdata;
                    end
                end else if (cnt_q == c_last_wait) begin
                    mem_rd_d      = 1'b0;
                    mem_wr_d      = 1'b0;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd_data_q     <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd_data_q     <= rd_data_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire
